// File: rtl/exception_ctrl_if.sv
// Commit-side, CP0-record and fetch-redirect signals of the exception controller.
// The master modport is the controller itself; the slave modport is the pipeline/CP0 side.
interface exception_ctrl_if;
  // Committing instruction
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic [31:0] commit_mem_addr;

  // Per-instruction exception flags
  logic        ex_adel_if;
  logic        ex_ri;
  logic        ex_sys;
  logic        ex_bp;
  logic        ex_ov;
  logic        ex_adel_ld;
  logic        ex_ades_st;
  logic        is_eret;

  // CP0 status
  logic        allow_interrupt;
  logic [7:0]  interrupt_flag;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_cause;

  // CP0 exception record
  logic        exp_en;
  logic        exp_badvaddr_en;
  logic [31:0] exp_badvaddr;
  logic        exp_bd;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        exl_clean;
  logic        exp_probe_failure;

  // Pipeline control and fetch redirect
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    input  commit_valid, commit_pc, commit_bd, commit_mem_addr,
    input  ex_adel_if, ex_ri, ex_sys, ex_bp, ex_ov, ex_adel_ld, ex_ades_st, is_eret,
    input  allow_interrupt, interrupt_flag, cp0_epc, cp0_cause,
    output exp_en, exp_badvaddr_en, exp_badvaddr, exp_bd, exp_code, exp_epc,
    output exl_clean, exp_probe_failure,
    output flush, redirect_valid, redirect_pc,
    input  redirect_ready
  );

  modport slave (
    output commit_valid, commit_pc, commit_bd, commit_mem_addr,
    output ex_adel_if, ex_ri, ex_sys, ex_bp, ex_ov, ex_adel_ld, ex_ades_st, is_eret,
    output allow_interrupt, interrupt_flag, cp0_epc, cp0_cause,
    input  exp_en, exp_badvaddr_en, exp_badvaddr, exp_bd, exp_code, exp_epc,
    input  exl_clean, exp_probe_failure,
    input  flush, redirect_valid, redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/exception_ctrl.sv
// Commit-stage exception/interrupt controller: picks the highest-priority event, emits the
// one-cycle CP0 exception record, flushes the pipeline and holds a fetch redirect until accepted.
module exception_ctrl #(
  parameter logic [31:0] ExcVector = 32'hBFC0_0380,
  parameter logic [4:0]  IntCode   = 5'd0,
  parameter logic [4:0]  AdelCode  = 5'd4,
  parameter logic [4:0]  AdesCode  = 5'd5,
  parameter logic [4:0]  SysCode   = 5'd8,
  parameter logic [4:0]  BpCode    = 5'd9,
  parameter logic [4:0]  RiCode    = 5'd10,
  parameter logic [4:0]  OvCode    = 5'd12
) (
  input logic               clk,
  input logic               rst,
  exception_ctrl_if.master  exc_io
);

  typedef enum logic [0:0] {StIdle, StRedirect} state_e;

  state_e      state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        irq_pending;
  logic        exc_hit;
  logic [4:0]  exc_code;
  logic        exc_badv_en;
  logic [31:0] exc_badv;

  // Only ExcCode and BD are read back from Cause on ERET
  logic        unused_cause;
  assign unused_cause = ^{exc_io.cp0_cause[30:7], exc_io.cp0_cause[1:0]};

  assign irq_pending = exc_io.allow_interrupt && (|exc_io.interrupt_flag);

  // Priority decode of exceptions; ERET is handled separately as the lowest-priority event
  always_comb begin
    exc_hit     = 1'b1;
    exc_code    = IntCode;
    exc_badv_en = 1'b0;
    exc_badv    = 32'h0;
    if (irq_pending) begin
      exc_code = IntCode;
    end else if (exc_io.ex_adel_if) begin
      exc_code    = AdelCode;
      exc_badv_en = 1'b1;
      exc_badv    = exc_io.commit_pc;
    end else if (exc_io.ex_ri) begin
      exc_code = RiCode;
    end else if (exc_io.ex_ov) begin
      exc_code = OvCode;
    end else if (exc_io.ex_sys) begin
      exc_code = SysCode;
    end else if (exc_io.ex_bp) begin
      exc_code = BpCode;
    end else if (exc_io.ex_adel_ld) begin
      exc_code    = AdelCode;
      exc_badv_en = 1'b1;
      exc_badv    = exc_io.commit_mem_addr;
    end else if (exc_io.ex_ades_st) begin
      exc_code    = AdesCode;
      exc_badv_en = 1'b1;
      exc_badv    = exc_io.commit_mem_addr;
    end else begin
      exc_hit = 1'b0;
    end
  end

  always_comb begin
    state_d                  = state_q;
    redirect_pc_d            = redirect_pc_q;
    exc_io.exp_en            = 1'b0;
    exc_io.exp_badvaddr_en   = 1'b0;
    exc_io.exp_badvaddr      = 32'h0;
    exc_io.exp_bd            = 1'b0;
    exc_io.exp_code          = 5'd0;
    exc_io.exp_epc           = 32'h0;
    exc_io.exl_clean         = 1'b0;
    exc_io.flush             = 1'b0;
    exc_io.redirect_valid    = 1'b0;

    case (state_q)
      StIdle: begin
        if (exc_io.commit_valid) begin
          if (exc_hit) begin
            exc_io.exp_en          = 1'b1;
            exc_io.exp_badvaddr_en = exc_badv_en;
            exc_io.exp_badvaddr    = exc_badv;
            exc_io.exp_bd          = exc_io.commit_bd;
            exc_io.exp_code        = exc_code;
            exc_io.exp_epc         = exc_io.commit_bd ? exc_io.commit_pc - 32'd4
                                                      : exc_io.commit_pc;
            exc_io.flush           = 1'b1;
            redirect_pc_d          = ExcVector;
            state_d                = StRedirect;
          end else if (exc_io.is_eret) begin
            // Write back current EPC/Cause so only EXL changes in CP0
            exc_io.exp_en    = 1'b1;
            exc_io.exl_clean = 1'b1;
            exc_io.exp_bd    = exc_io.cp0_cause[31];
            exc_io.exp_code  = exc_io.cp0_cause[6:2];
            exc_io.exp_epc   = exc_io.cp0_epc;
            exc_io.flush     = 1'b1;
            redirect_pc_d    = exc_io.cp0_epc;
            state_d          = StRedirect;
          end
        end
      end
      StRedirect: begin
        exc_io.flush          = 1'b1;
        exc_io.redirect_valid = 1'b1;
        if (exc_io.redirect_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign exc_io.redirect_pc       = redirect_pc_q;
  assign exc_io.exp_probe_failure = 1'b0;

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: stimulus pushes expected per-cycle behaviour from a
// priority-table reference model; a negedge monitor pops and compares.
module tb_exception_ctrl;
  localparam logic [31:0] ExcVec = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exception_ctrl_if bus ();

  exception_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .exc_io (bus)
  );

  typedef struct {
    bit          cv;
    bit   [31:0] pc;
    bit          bd;
    bit   [31:0] addr;
    bit          adel_if, ri, sys, bp, ov, adel_ld, ades_st, eret;
    bit          allow;
    bit   [7:0]  iflag;
    bit   [31:0] epc;
    bit   [31:0] cause;
    bit          ready;
    bit          rst;
  } stim_t;

  typedef struct {
    bit          exp_en, flush, rv;
    bit          exl_clean, bd, badv_en;
    bit   [4:0]  code;
    bit   [31:0] epc, badv;
  } cyc_t;

  cyc_t        cyc_q[$];
  bit   [31:0] redir_q[$];
  bit          busy = 1'b0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s = '{default: 0};
    s.ready = 1'b1;
    return s;
  endfunction

  // Reference model: ordered priority table, first set entry wins
  task automatic step(input stim_t s);
    cyc_t    e;
    bit [8:0] pri;
    int      idx;
    int unsigned code_tab[8] = '{0, 4, 10, 12, 8, 9, 4, 5};
    @(posedge clk);
    #1;
    rst                 = s.rst;
    bus.commit_valid    = s.cv;
    bus.commit_pc       = s.pc;
    bus.commit_bd       = s.bd;
    bus.commit_mem_addr = s.addr;
    bus.ex_adel_if      = s.adel_if;
    bus.ex_ri           = s.ri;
    bus.ex_sys          = s.sys;
    bus.ex_bp           = s.bp;
    bus.ex_ov           = s.ov;
    bus.ex_adel_ld      = s.adel_ld;
    bus.ex_ades_st      = s.ades_st;
    bus.is_eret         = s.eret;
    bus.allow_interrupt = s.allow;
    bus.interrupt_flag  = s.iflag;
    bus.cp0_epc         = s.epc;
    bus.cp0_cause       = s.cause;
    bus.redirect_ready  = s.ready;
    mon_en              = 1'b1;

    e = '{default: 0};
    if (busy) begin
      e.flush = 1'b1;
      e.rv    = 1'b1;
      if (s.ready || s.rst) busy = 1'b0;
    end else if (s.cv && !s.rst) begin
      pri = {s.eret, s.ades_st, s.adel_ld, s.bp, s.sys, s.ov, s.ri, s.adel_if,
             (s.allow && s.iflag != 8'h0)};
      idx = -1;
      for (int i = 0; i < 9; i++) begin
        if (pri[i]) begin
          idx = i;
          break;
        end
      end
      if (idx >= 0 && idx < 8) begin
        e.exp_en  = 1'b1;
        e.flush   = 1'b1;
        e.bd      = s.bd;
        e.code    = 5'(code_tab[idx]);
        e.epc     = s.bd ? s.pc - 32'd4 : s.pc;
        e.badv_en = (idx == 1) || (idx >= 6);
        e.badv    = (idx == 1) ? s.pc : ((idx >= 6) ? s.addr : 32'h0);
        redir_q.push_back(ExcVec);
        busy = 1'b1;
      end else if (idx == 8) begin
        e.exp_en    = 1'b1;
        e.flush     = 1'b1;
        e.exl_clean = 1'b1;
        e.bd        = s.cause[31];
        e.code      = s.cause[6:2];
        e.epc       = s.epc;
        redir_q.push_back(s.epc);
        busy = 1'b1;
      end
    end
    cyc_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    cyc_t e;
    if (mon_en && cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("exp_en", 32'(bus.exp_en), 32'(e.exp_en));
      chk("flush", 32'(bus.flush), 32'(e.flush));
      chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
      chk("probe_failure", 32'(bus.exp_probe_failure), 32'h0);
      if (e.exp_en) begin
        chk("exl_clean", 32'(bus.exl_clean), 32'(e.exl_clean));
        chk("exp_code", 32'(bus.exp_code), 32'(e.code));
        chk("exp_epc", bus.exp_epc, e.epc);
        chk("exp_bd", 32'(bus.exp_bd), 32'(e.bd));
        chk("badvaddr_en", 32'(bus.exp_badvaddr_en), 32'(e.badv_en));
        if (e.badv_en) chk("badvaddr", bus.exp_badvaddr, e.badv);
      end
    end
    if (mon_en && bus.redirect_valid) begin
      if (redir_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL redirect_unexpected: got valid=1 expected no pending redirect");
      end else begin
        chk("redirect_pc", bus.redirect_pc, redir_q[0]);
        if (bus.redirect_ready || rst) void'(redir_q.pop_front());
      end
    end
  end

  initial begin
    stim_t s;
    s = idle_s();
    s.rst = 1'b1;
    s.ready = 1'b0;
    rst = 1'b1;
    bus.commit_valid = 1'b0;
    bus.redirect_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_exp_en", 32'(bus.exp_en), 32'h0);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'h0);

    // Overflow, not in delay slot
    s = idle_s(); s.cv = 1; s.pc = 32'h8000_0100; s.ov = 1; step(s);
    step(idle_s());
    step(idle_s());
    // Load AdEL in delay slot
    s = idle_s(); s.cv = 1; s.pc = 32'h8000_0204; s.bd = 1; s.addr = 32'h3; s.adel_ld = 1;
    step(s);
    step(idle_s());
    // Interrupt beats syscall
    s = idle_s(); s.cv = 1; s.pc = 32'h8000_0300; s.allow = 1; s.iflag = 8'h04; s.sys = 1;
    step(s);
    step(idle_s());
    // Pending interrupt without a valid commit is not taken
    s = idle_s(); s.allow = 1; s.iflag = 8'h80; step(s);
    // ERET
    s = idle_s(); s.cv = 1; s.eret = 1; s.epc = 32'h8000_1000; s.cause = 32'h8000_0030;
    step(s);
    step(idle_s());
    // Redirect stall with a new RI commit presented
    s = idle_s(); s.cv = 1; s.pc = 32'h8000_0400; s.ri = 1; step(s);
    s.ready = 0;
    repeat (3) step(s);
    s.ready = 1; step(s);
    step(idle_s());
    // Reset during redirect
    s = idle_s(); s.cv = 1; s.pc = 32'h8000_0500; s.bp = 1; step(s);
    s = idle_s(); s.ready = 0; s.rst = 1; step(s);
    s = idle_s(); s.ready = 0; step(s);
    step(idle_s());

    for (int n = 0; n < 600; n++) begin
      s.rst     = ($urandom_range(0, 39) == 0);
      s.cv      = !s.rst && ($urandom_range(0, 9) < 7);
      s.pc      = $urandom;
      s.bd      = $urandom_range(0, 1) == 1;
      s.addr    = $urandom;
      s.adel_if = $urandom_range(0, 9) == 0;
      s.ri      = $urandom_range(0, 9) == 0;
      s.sys     = $urandom_range(0, 9) == 0;
      s.bp      = $urandom_range(0, 9) == 0;
      s.ov      = $urandom_range(0, 9) == 0;
      s.adel_ld = $urandom_range(0, 9) == 0;
      s.ades_st = $urandom_range(0, 9) == 0;
      s.eret    = $urandom_range(0, 5) == 0;
      s.allow   = $urandom_range(0, 1) == 1;
      s.iflag   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      s.epc     = $urandom;
      s.cause   = $urandom;
      s.ready   = $urandom_range(0, 1) == 1;
      step(s);
    end
    repeat (3) step(idle_s());
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(cyc_q.size()), 32'h0);
    chk("redirects_drained", 32'(redir_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Commit-stage exception/interrupt controller for the Sirius MIPS pipeline; the producer side of the CP0 exception interface.
- Each cycle it takes the committing instruction's exception flags plus the CP0 interrupt status, picks the highest-priority event, and drives the one-cycle CP0 exception record.
- It also asserts a pipeline flush and holds a fetch redirect (exception vector or EPC) until fetch accepts it.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, general exception entry PC
INT_CODE/ADEL_CODE/ADES_CODE/SYS_CODE/BP_CODE/RI_CODE/OV_CODE, 0/4/5/8/9/10/12, ExcCode values

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
commit_valid  in  1  instruction present at commit this cycle
commit_pc  in  32  PC of committing instruction
commit_bd  in  1  instruction is in a branch delay slot
commit_mem_addr  in  32  load/store effective address
ex_adel_if  in  1  fetch address error
ex_ri  in  1  reserved instruction
ex_sys  in  1  syscall
ex_bp  in  1  break
ex_ov  in  1  arithmetic overflow
ex_adel_ld  in  1  load address error
ex_ades_st  in  1  store address error
is_eret  in  1  committing instruction is ERET
allow_interrupt  in  1  from CP0
interrupt_flag  in  8  from CP0 (IM & IP)
cp0_epc  in  32  current EPC
cp0_cause  in  32  current Cause
exp_en  out  1  CP0 exception record strobe
exp_badvaddr_en  out  1  update BadVAddr
exp_badvaddr  out  32  faulting address
exp_bd  out  1  branch-delay flag
exp_code  out  5  ExcCode
exp_epc  out  32  EPC value
exl_clean  out  1  1 = clear EXL (ERET), 0 = set EXL
exp_probe_failure  out  1  tied 0 in this revision
flush  out  1  kill all younger pipeline stages
redirect_valid  out  1  fetch redirect request
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts redirect

Behaviour:
- FSM states: IDLE, REDIRECT. Reset → IDLE; all outputs 0, redirect_pc 0.
- An event is taken only in IDLE with commit_valid=1. In REDIRECT, commit_valid and all flags are ignored and exp_en stays 0.
- Priority, highest first:
  1. interrupt: allow_interrupt && |interrupt_flag
  2. ex_adel_if
  3. ex_ri
  4. ex_ov
  5. ex_sys
  6. ex_bp
  7. ex_adel_ld
  8. ex_ades_st
  9. is_eret
- Exception taken (priorities 1–8), combinational in the commit cycle:
  - exp_en=1, exl_clean=0, exp_bd=commit_bd.
  - exp_epc = commit_bd ? commit_pc-4 : commit_pc (32-bit, wraps).
  - exp_code per the table.
  - exp_badvaddr_en=1 only for AdEL/AdES.
  - exp_badvaddr = commit_pc for fetch AdEL; commit_mem_addr for data AdEL/AdES; 0 otherwise.
- ERET taken, combinational in the commit cycle:
  - exp_en=1, exl_clean=1, exp_badvaddr_en=0.
  - exp_epc=cp0_epc, exp_code=cp0_cause[6:2], exp_bd=cp0_cause[31], so CP0 state other than EXL is preserved.
- Any taken event:
  - flush=1 in the same cycle.
  - Next cycle enters REDIRECT with redirect_valid=1.
  - redirect_pc is registered: EXC_VECTOR for exceptions, cp0_epc sampled at the ERET commit.
- REDIRECT:
  - flush stays 1.
  - redirect_valid and redirect_pc held stable until redirect_ready=1.
  - On the ready cycle: return to IDLE, flush and redirect_valid drop next cycle.
- commit_valid=0 in IDLE: no event, even with an interrupt pending; the interrupt is taken on the next valid commit.
- Multiple flags set: only the highest-priority event is reported; the rest are discarded.
- rst while in REDIRECT: return to IDLE next edge, with redirect_valid=0 and flush=0.
- exp_en is at most one cycle per taken event. Back-to-back events are impossible, because a minimum of 2 cycles passes between exp_en pulses.

Test Plan:
- Overflow at commit_pc=0x8000_0100, bd=0 → exp_en 1 cycle, exp_code=12, exp_epc=0x8000_0100, flush=1; next cycle redirect_valid=1, redirect_pc=0xBFC0_0380.
- Load AdEL in delay slot, pc=0x8000_0204, addr=0x0000_0003 → exp_code=4, exp_bd=1, exp_epc=0x8000_0200, exp_badvaddr_en=1, badvaddr=0x0000_0003.
- allow_interrupt=1, interrupt_flag=0x04, with ex_sys=1 on the same commit → exp_code=0 (interrupt wins), syscall dropped.
- ERET with cp0_epc=0x8000_1000, cp0_cause=0x8000_0030 → exl_clean=1, exp_epc=0x8000_1000, exp_code=12, exp_bd=1; redirect_pc=0x8000_1000.
- redirect_ready held 0 for 3 cycles with commit_valid=1 and ex_ri=1 → redirect_valid/flush held, redirect_pc stable, exp_en stays 0; ready=1 → IDLE.
- rst in REDIRECT → next cycle redirect_valid=0, flush=0, exp_en=0.
